// File: rtl/cr_logic_station_if.sv
// Dispatch, CR result-bus snoop and result handshake for the CR-logical station.
// The master side is the dispatcher, the CR broadcast bus and the writeback consumer.
// The slave side is the reservation station.
interface cr_logic_station_if #(
  parameter int RS_ID_WIDTH = 5
);
  // dispatch port
  logic                   in_valid;
  logic                   in_ready;
  logic [RS_ID_WIDTH-1:0] alloc_rs_id;
  logic [3:0]             in_op;
  logic [4:0]             in_ba;
  logic [4:0]             in_bb;
  logic [4:0]             in_bt;
  logic [2:0]             in_src_valid;
  logic [3:0]             in_src_value [3];
  logic [RS_ID_WIDTH-1:0] in_src_rs_id [3];

  // per-field CR result broadcast
  logic [7:0]             cdb_enable;
  logic [31:0]            cdb_value;
  logic [RS_ID_WIDTH-1:0] cdb_rs_id [8];

  // result port
  logic                   res_valid;
  logic                   res_ready;
  logic [2:0]             res_field;
  logic [3:0]             res_value;
  logic [RS_ID_WIDTH-1:0] res_rs_id;

  modport master (
    output in_valid, in_op, in_ba, in_bb, in_bt, in_src_valid, in_src_value, in_src_rs_id,
    output cdb_enable, cdb_value, cdb_rs_id,
    output res_ready,
    input  in_ready, alloc_rs_id,
    input  res_valid, res_field, res_value, res_rs_id
  );

  modport slave (
    input  in_valid, in_op, in_ba, in_bb, in_bt, in_src_valid, in_src_value, in_src_rs_id,
    input  cdb_enable, cdb_value, cdb_rs_id,
    input  res_ready,
    output in_ready, alloc_rs_id,
    output res_valid, res_field, res_value, res_rs_id
  );
endinterface

// File: rtl/cr_logic_station.sv
// Reservation station plus execute stage for the CR-logical ops.
// Entries wait for three 4-bit CR-field operands (BA field, BB field, old BT field),
// wake up by snooping the per-field CR result bus, and the lowest ready entry issues
// into a single registered result slot. CR bit numbers use big-endian numbering:
// bits [4:2] select the field, bits [1:0] the bit within the field (0 = MSB).
module cr_logic_station #(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int RS_ID_BASE  = 8
) (
  input logic            clk,
  input logic            rst,
  cr_logic_station_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [RS_ID_WIDTH-1:0] tag_t;

  // entry storage; operand index 0 = BA field, 1 = BB field, 2 = old BT field
  logic [DEPTH-1:0] ent_valid;
  logic [3:0]       ent_op  [DEPTH];
  logic [4:0]       ent_bit [DEPTH][3];
  logic [2:0]       ent_opv [DEPTH];
  logic [3:0]       ent_val [DEPTH][3];
  tag_t             ent_tag [DEPTH][3];

  // result register
  logic       res_valid_q;
  logic [2:0] res_field_q;
  logic [3:0] res_value_q;
  tag_t       res_rs_id_q;

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] iss_idx;
  logic             alloc_ok;
  logic             iss_ok;
  logic             issue;
  logic             dispatch;
  logic [2:0]       snoop_hit [DEPTH];
  logic [4:0]       disp_bit  [3];
  logic [2:0]       disp_hit;
  logic             a_bit;
  logic             b_bit;
  logic             r_bit;
  logic [3:0]       new_val;

  // pick the lowest free entry for allocation and the lowest fully-woken entry for issue
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    iss_ok    = 1'b0;
    iss_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (ent_valid[i] && (&ent_opv[i])) begin
        iss_ok  = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  // tag matches against the broadcast bus, both for stored entries and for the op being dispatched
  always_comb begin
    disp_bit[0] = bus.in_ba;
    disp_bit[1] = bus.in_bb;
    disp_bit[2] = bus.in_bt;
    for (int k = 0; k < 3; k++) begin
      disp_hit[k] = !bus.in_src_valid[k] && bus.cdb_enable[disp_bit[k][4:2]] &&
                    (bus.cdb_rs_id[disp_bit[k][4:2]] == bus.in_src_rs_id[k]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        snoop_hit[i][k] = ent_valid[i] && !ent_opv[i][k] && bus.cdb_enable[ent_bit[i][k][4:2]] &&
                          (bus.cdb_rs_id[ent_bit[i][k][4:2]] == ent_tag[i][k]);
      end
    end
  end

  // evaluate the truth table for the issuing entry and splice the bit into the old BT field
  always_comb begin
    a_bit   = ent_val[iss_idx][0][~ent_bit[iss_idx][0][1:0]];
    b_bit   = ent_val[iss_idx][1][~ent_bit[iss_idx][1][1:0]];
    r_bit   = ent_op[iss_idx][{a_bit, b_bit}];
    new_val = ent_val[iss_idx][2];
    new_val[~ent_bit[iss_idx][2][1:0]] = r_bit;
  end

  assign issue    = iss_ok && (!res_valid_q || bus.res_ready);
  assign dispatch = bus.in_valid && alloc_ok;

  assign bus.in_ready    = alloc_ok;
  assign bus.alloc_rs_id = alloc_ok ? tag_t'(RS_ID_BASE) + tag_t'(alloc_idx) : tag_t'(RS_ID_BASE);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_field   = res_field_q;
  assign bus.res_value   = res_value_q;
  assign bus.res_rs_id   = res_rs_id_q;

  // entry lifecycle (snoop, free on issue, fill on dispatch) and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid   <= '0;
      res_valid_q <= 1'b0;
      res_field_q <= '0;
      res_value_q <= '0;
      res_rs_id_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (snoop_hit[i][k]) begin
            ent_opv[i][k] <= 1'b1;
            ent_val[i][k] <= bus.cdb_value[{ent_bit[i][k][4:2], 2'b00} +: 4];
          end
        end
      end

      if (issue) begin
        ent_valid[iss_idx] <= 1'b0;
      end

      if (dispatch) begin
        ent_valid[alloc_idx] <= 1'b1;
        ent_op[alloc_idx]    <= bus.in_op;
        for (int k = 0; k < 3; k++) begin
          ent_bit[alloc_idx][k] <= disp_bit[k];
          ent_tag[alloc_idx][k] <= bus.in_src_rs_id[k];
          if (bus.in_src_valid[k]) begin
            ent_opv[alloc_idx][k] <= 1'b1;
            ent_val[alloc_idx][k] <= bus.in_src_value[k];
          end else if (disp_hit[k]) begin
            ent_opv[alloc_idx][k] <= 1'b1;
            ent_val[alloc_idx][k] <= bus.cdb_value[{disp_bit[k][4:2], 2'b00} +: 4];
          end else begin
            ent_opv[alloc_idx][k] <= 1'b0;
            ent_val[alloc_idx][k] <= '0;
          end
        end
      end

      if (issue) begin
        res_valid_q <= 1'b1;
        res_field_q <= ent_bit[iss_idx][2][4:2];
        res_value_q <= new_val;
        res_rs_id_q <= tag_t'(RS_ID_BASE) + tag_t'(iss_idx);
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cr_logic_station.sv
// Directed bench for cr_logic_station. Expected results are hand-computed and queued
// when the op is dispatched; a monitor pops and compares on every result handshake.
module tb_cr_logic_station;

  logic clk;
  logic rst;

  typedef struct packed {
    logic [2:0] f;
    logic [3:0] v;
    logic [4:0] t;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  cr_logic_station_if #(.RS_ID_WIDTH(5)) bus ();

  cr_logic_station #(
    .RS_ID_WIDTH(5),
    .DEPTH      (4),
    .RS_ID_BASE (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, want);
    end
  endtask

  // dispatch one op for a single cycle; operand k is bit k of sv
  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] ba, input logic [4:0] bb,
                               input logic [4:0] bt, input logic [2:0] sv,
                               input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vd,
                               input logic [4:0] ta, input logic [4:0] tb2, input logic [4:0] td);
    bus.in_valid        = 1'b1;
    bus.in_op           = op;
    bus.in_ba           = ba;
    bus.in_bb           = bb;
    bus.in_bt           = bt;
    bus.in_src_valid    = sv;
    bus.in_src_value[0] = va;
    bus.in_src_value[1] = vb;
    bus.in_src_value[2] = vd;
    bus.in_src_rs_id[0] = ta;
    bus.in_src_rs_id[1] = tb2;
    bus.in_src_rs_id[2] = td;
    tick();
    bus.in_valid     = 1'b0;
    bus.in_src_valid = 3'b000;
  endtask

  // one-cycle broadcast of a single CR field
  task automatic broadcast(input logic [2:0] f, input logic [4:0] t, input logic [3:0] v);
    bus.cdb_enable   = 8'(1) << f;
    bus.cdb_rs_id[f] = t;
    bus.cdb_value    = 32'(v) << (4 * f);
    tick();
    bus.cdb_enable = 8'h00;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.res_valid) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'((sb.size() != 0) || bus.res_valid), 32'd0);
  endtask

  // scoreboard monitor: compare each accepted result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got field=%0d value=%0h tag=%0d required none",
                 bus.res_field, bus.res_value, bus.res_rs_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("res_field", 32'(bus.res_field), 32'(e.f));
        checkOutput("res_value", 32'(bus.res_value), 32'(e.v));
        checkOutput("res_rs_id", 32'(bus.res_rs_id), 32'(e.t));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_op        = 4'h0;
    bus.in_ba        = 5'd0;
    bus.in_bb        = 5'd0;
    bus.in_bt        = 5'd0;
    bus.in_src_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      bus.in_src_value[k] = 4'h0;
      bus.in_src_rs_id[k] = 5'd0;
    end
    bus.cdb_enable = 8'h00;
    bus.cdb_value  = 32'h0;
    for (int f = 0; f < 8; f++) bus.cdb_rs_id[f] = 5'd0;
    bus.res_ready = 1'b1;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_alloc", 32'(bus.alloc_rs_id), 32'd8);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_value", 32'(bus.res_value), 32'd0);
    checkOutput("rst_res_rs_id", 32'(bus.res_rs_id), 32'd0);

    // all operands valid: and of field0 bits 1 and 2 into bit 3, 0110 -> 0111
    sb.push_back('{f: 3'd0, v: 4'b0111, t: 5'd8});
    applyStimulus(4'b1000, 5'd1, 5'd2, 5'd3, 3'b111, 4'b0110, 4'b0110, 4'b0110, 5'd0, 5'd0, 5'd0);
    checkOutput("lat_early", 32'(bus.res_valid), 32'd0);
    tick();
    checkOutput("lat_valid", 32'(bus.res_valid), 32'd1);
    waitDrain(20);

    // wakeup: BB pending on tag 9 in field 5; and(1,1) into field2 bit3, 1010 -> 1011
    sb.push_back('{f: 3'd2, v: 4'b1011, t: 5'd8});
    applyStimulus(4'b1000, 5'd4, 5'd20, 5'd11, 3'b101, 4'b1000, 4'b0000, 4'b1010, 5'd0, 5'd9, 5'd0);
    tick();
    tick();
    checkOutput("no_early_issue", 32'(bus.res_valid), 32'd0);
    broadcast(3'd5, 5'd10, 4'hF);
    tick();
    checkOutput("wrong_tag_ignored", 32'(bus.res_valid), 32'd0);
    broadcast(3'd5, 5'd9, 4'hF);
    checkOutput("wake_not_yet", 32'(bus.res_valid), 32'd0);
    tick();
    checkOutput("wake_issue", 32'(bus.res_valid), 32'd1);
    waitDrain(20);

    // dispatch bypass: BA pending on tag 12 (field 3) broadcast in the dispatch cycle; nor(0,0)
    sb.push_back('{f: 3'd4, v: 4'b1000, t: 5'd8});
    bus.cdb_enable   = 8'b0000_1000;
    bus.cdb_rs_id[3] = 5'd12;
    bus.cdb_value    = 32'h0000_7000;
    applyStimulus(4'b0001, 5'd12, 5'd1, 5'd16, 3'b110, 4'b0000, 4'b0000, 4'b0000, 5'd12, 5'd0, 5'd0);
    bus.cdb_enable = 8'h00;
    waitDrain(20);

    // fill all entries with BA pending on tags 20..23 (field 6)
    for (int i = 0; i < 4; i++) begin
      checkOutput("alloc_fill", 32'(bus.alloc_rs_id), 32'(8 + i));
      applyStimulus(4'b1000, 5'd24, 5'd0, 5'd29, 3'b110, 4'b0000, 4'b1000, 4'b0000,
                    5'(20 + i), 5'd0, 5'd0);
    end
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_alloc", 32'(bus.alloc_rs_id), 32'd8);
    applyStimulus(4'b1111, 5'd0, 5'd0, 5'd0, 3'b111, 4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0);
    sb.push_back('{f: 3'd7, v: 4'b0100, t: 5'd10});
    broadcast(3'd6, 5'd22, 4'b1000);
    checkOutput("full_before_issue", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("freed_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("freed_alloc", 32'(bus.alloc_rs_id), 32'd10);
    sb.push_back('{f: 3'd7, v: 4'b0000, t: 5'd8});
    broadcast(3'd6, 5'd20, 4'b0000);
    sb.push_back('{f: 3'd7, v: 4'b0000, t: 5'd9});
    broadcast(3'd6, 5'd21, 4'b0000);
    sb.push_back('{f: 3'd7, v: 4'b0000, t: 5'd11});
    broadcast(3'd6, 5'd23, 4'b0000);
    waitDrain(20);

    // backpressure: xor result held for 3 cycles, then or result follows back-to-back
    bus.res_ready = 1'b0;
    sb.push_back('{f: 3'd2, v: 4'b1000, t: 5'd8});
    sb.push_back('{f: 3'd3, v: 4'b1110, t: 5'd9});
    applyStimulus(4'b0110, 5'd0, 5'd4, 5'd8, 3'b111, 4'b1000, 4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0);
    applyStimulus(4'b1110, 5'd0, 5'd4, 5'd15, 3'b111, 4'b0000, 4'b0000, 4'b1111, 5'd0, 5'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("stall_field", 32'(bus.res_field), 32'd2);
      checkOutput("stall_value", 32'(bus.res_value), 32'b1000);
      checkOutput("stall_rs_id", 32'(bus.res_rs_id), 32'd8);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    checkOutput("b2b_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("b2b_rs_id", 32'(bus.res_rs_id), 32'd9);
    checkOutput("b2b_value", 32'(bus.res_value), 32'b1110);
    waitDrain(20);

    // reset with three busy entries and a held result: everything discarded
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0110, 5'd0, 5'd4, 5'd8, 3'b111, 4'b1000, 4'b0000, 4'b0000, 5'd0, 5'd0, 5'd0);
    end
    checkOutput("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    rst = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    checkOutput("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid_rst_alloc", 32'(bus.alloc_rs_id), 32'd8);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("post_rst_quiet", 32'(bus.res_valid), 32'd0);
    end

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
